// File: rtl/fetch_sequencer.sv
// Program-counter and fetch sequencer: steps or branches the instruction address each
// RUN cycle, runs the Start/Done handshake and keeps saturating cycle/branch counters.
//
// state | meaning
// IDLE  | after reset, waiting for Start
// ARM   | Start held: PC forced to START_ADDR, counters cleared
// RUN   | one PC update per cycle
// DONE  | halted, PC and counters frozen until the next Start
module fetch_sequencer #(
    parameter int          PC_W       = 10,
    parameter int unsigned START_ADDR = 0,
    parameter int          CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    input  logic             BranchRel,
    input  logic             BranchAbs,
    input  logic             Taken,
    input  logic [PC_W-1:0]  Target,
    output logic [PC_W-1:0]  ProgCounter,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount,
    output logic [CNT_W-1:0] BranchCount
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    localparam logic [PC_W-1:0]  PC_START = PC_W'(START_ADDR);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state, state_nxt;
    logic [PC_W-1:0]  pc, pc_nxt;
    logic [CNT_W-1:0] cyc, cyc_nxt;
    logic [CNT_W-1:0] brc, brc_nxt;
    logic [CNT_W-1:0] cyc_inc, brc_inc;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            pc    <= PC_START;
            cyc   <= '0;
            brc   <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            cyc   <= cyc_nxt;
            brc   <= brc_nxt;
        end
    end

    assign cyc_inc = (cyc == CNT_MAX) ? cyc : cyc + CNT_W'(1);
    assign brc_inc = (brc == CNT_MAX) ? brc : brc + CNT_W'(1);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cyc_nxt   = cyc;
        brc_nxt   = brc;
        case (state)
            IDLE: begin
                if (Start) state_nxt = ARM;
            end
            ARM: begin
                pc_nxt  = PC_START;
                cyc_nxt = '0;
                brc_nxt = '0;
                if (!Start) state_nxt = RUN;
            end
            RUN: begin
                cyc_nxt = cyc_inc;
                // abort wins over everything; the PC reload is left to ARM
                if (Start) begin
                    state_nxt = ARM;
                end else if (Halt) begin
                    state_nxt = DONE;
                end else if (BranchAbs && Taken) begin
                    pc_nxt  = Target;
                    brc_nxt = brc_inc;
                end else if (BranchRel && Taken) begin
                    pc_nxt  = pc + Target;
                    brc_nxt = brc_inc;
                end else begin
                    pc_nxt = pc + PC_W'(1);
                end
            end
            DONE: begin
                if (Start) state_nxt = ARM;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ProgCounter = pc;
    assign Running     = (state == RUN);
    assign Done        = (state == DONE);
    assign CycleCount  = cyc;
    assign BranchCount = brc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; a second instance with 4-bit counters
// shares the stimulus to exercise counter saturation.
module tb_fetch_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start, Halt, BranchRel, BranchAbs, Taken;
    logic [9:0]  Target;
    logic [9:0]  ProgCounter;
    logic        Running, Done;
    logic [15:0] CycleCount, BranchCount;
    logic [9:0]  pc_s;
    logic        run_s, done_s;
    logic [3:0]  cyc_s, brc_s;

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(.PC_W(10), .START_ADDR(0), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
        .BranchRel(BranchRel), .BranchAbs(BranchAbs), .Taken(Taken), .Target(Target),
        .ProgCounter(ProgCounter), .Running(Running), .Done(Done),
        .CycleCount(CycleCount), .BranchCount(BranchCount)
    );

    fetch_sequencer #(.PC_W(10), .START_ADDR(0), .CNT_W(4)) dut_sat (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
        .BranchRel(BranchRel), .BranchAbs(BranchAbs), .Taken(Taken), .Target(Target),
        .ProgCounter(pc_s), .Running(run_s), .Done(done_s),
        .CycleCount(cyc_s), .BranchCount(brc_s)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_dec();
        Halt = 0; BranchRel = 0; BranchAbs = 0; Taken = 0; Target = '0;
    endtask

    // Start for one edge, drop it for the next: lands in RUN with PC=0
    task automatic start_run();
        Start = 1; tick();
        Start = 0; tick();
    endtask

    task automatic jump(input logic [9:0] t);
        BranchAbs = 1; Taken = 1; Target = t;
        tick();
        clear_dec();
    endtask

    initial begin
        Reset = 1; Start = 0; clear_dec();
        #2;
        chk("rst_pc", ProgCounter, 0);
        chk("rst_run", Running, 0);
        chk("rst_done", Done, 0);
        chk("rst_cyc", CycleCount, 0);
        #5 Reset = 0;
        tick();
        chk("idle_run", Running, 0);
        chk("idle_done", Done, 0);

        // sequential fetch then halt
        Start = 1; tick();
        chk("arm1_run", Running, 0);
        tick();
        chk("arm2_run", Running, 0);
        Start = 0; tick();
        chk("run_first", Running, 1);
        chk("seq_pc0", ProgCounter, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("seq_pc", ProgCounter, i);
        end
        Halt = 1; tick(); Halt = 0;
        chk("halt_done", Done, 1);
        chk("halt_run", Running, 0);
        chk("halt_pc", ProgCounter, 5);
        chk("halt_cyc", CycleCount, 6);
        chk("halt_brc", BranchCount, 0);

        // decodes ignored in DONE
        BranchAbs = 1; Taken = 1; Target = 10'd300; tick(); clear_dec();
        chk("done_hold_pc", ProgCounter, 5);
        chk("done_hold_cyc", CycleCount, 6);

        // relative branches
        start_run();
        chk("rerun_pc", ProgCounter, 0);
        chk("rerun_cyc", CycleCount, 0);
        jump(10'd402);
        chk("abs_402", ProgCounter, 402);
        BranchRel = 1; Taken = 1; Target = 10'h26E; tick(); clear_dec();
        chk("rel_back", ProgCounter, 0);
        chk("rel_brc", BranchCount, 2);
        jump(10'd402);
        BranchRel = 1; Taken = 0; Target = 10'h26E; tick(); clear_dec();
        chk("rel_nt_pc", ProgCounter, 403);
        chk("rel_nt_brc", BranchCount, 3);

        // absolute beats relative
        jump(10'd10);
        BranchAbs = 1; BranchRel = 1; Taken = 1; Target = 10'd700; tick(); clear_dec();
        chk("abs_prio", ProgCounter, 700);

        // wrap-around
        jump(10'd1023);
        tick();
        chk("wrap_inc", ProgCounter, 0);
        jump(10'd1000);
        BranchRel = 1; Taken = 1; Target = 10'd100; tick(); clear_dec();
        chk("wrap_rel", ProgCounter, 76);

        // halt beats a taken jump
        jump(10'd20);
        Halt = 1; BranchAbs = 1; Taken = 1; Target = 10'd500; tick(); clear_dec();
        chk("halt_prio_pc", ProgCounter, 20);
        chk("halt_prio_done", Done, 1);
        chk("halt_prio_brc", BranchCount, 9);
        chk("halt_prio_cyc", CycleCount, 12);

        // abort a run with Start
        start_run();
        jump(10'd50);
        Start = 1; tick();
        chk("abort_run", Running, 0);
        chk("abort_done", Done, 0);
        tick();
        chk("abort_pc", ProgCounter, 0);
        chk("abort_cyc", CycleCount, 0);
        chk("abort_brc", BranchCount, 0);
        Start = 0; tick();
        chk("abort_resume", Running, 1);
        tick();
        chk("abort_pc1", ProgCounter, 1);

        // saturation: 1 RUN cycle so far, 20 more
        for (int i = 0; i < 20; i++) tick();
        chk("sat_wide", CycleCount, 21);
        chk("sat_small", cyc_s, 15);
        chk("sat_pc", pc_s, 21);

        // asynchronous reset mid-run
        jump(10'd37);
        chk("pre_rst_pc", ProgCounter, 37);
        #2 Reset = 1;
        #1;
        chk("arst_pc", ProgCounter, 0);
        chk("arst_run", Running, 0);
        chk("arst_done", Done, 0);
        chk("arst_cyc", CycleCount, 0);
        chk("arst_brc", BranchCount, 0);
        #2 Reset = 0;
        tick();
        chk("post_rst_run", Running, 0);
        tick();
        chk("post_rst_pc", ProgCounter, 0);
        chk("post_rst_idle", Running, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter and fetch sequencer for the 3BC processor. It sits directly downstream of the PC-target lookup table: it consumes the 10-bit target/offset the table produces, along with the branch and halt decodes, and produces the instruction-memory address each cycle. It also owns the Start/Done run handshake with the testbench, and keeps cycle and taken-branch counters for performance reporting.

## Interface
- PC_W, 10, program-counter and target width (instruction memory depth 2^PC_W)
- START_ADDR, 0, PC value loaded on reset and on every (re)arm
- CNT_W, 16, width of the performance counters
- Clk  input  1  single clock, all state updates on rising edge
- Reset  input  1  asynchronous, active-high; clears all state immediately
- Start  input  1  run request from the testbench; level-sensitive
- Halt  input  1  decoded halt instruction in the current cycle
- BranchRel  input  1  decoded PC-relative branch
- BranchAbs  input  1  decoded absolute jump
- Taken  input  1  branch condition result; qualifies BranchRel and BranchAbs
- Target  input  PC_W  lookup-table output; two's-complement offset for relative, address for absolute
- ProgCounter  output  PC_W  current instruction address, registered
- Running  output  1  high while in RUN
- Done  output  1  high while in DONE
- CycleCount  output  CNT_W  cycles spent in RUN, saturating
- BranchCount  output  CNT_W  taken branches/jumps, saturating

## Operation
- States: IDLE, ARM, RUN, DONE. Encoding is free.
- Reset (async): state=IDLE, ProgCounter=START_ADDR, Running=0, Done=0, CycleCount=0, BranchCount=0.
- IDLE: Start=1 -> ARM.
- ARM:
  - Each cycle, ProgCounter=START_ADDR and both counters are cleared.
  - Stays in ARM while Start=1. Start=0 -> RUN.
- RUN: one PC update per cycle, in priority order:
  - Halt=1 -> PC held, next state DONE.
  - BranchAbs & Taken -> PC = Target.
  - BranchRel & Taken -> PC = PC + Target, modulo 2^PC_W. Target is sign-interpreted, so Target=10'h26E (-402) moves the PC back 402.
  - Otherwise PC = PC + 1, wrapping 2^PC_W-1 -> 0.
  - BranchAbs and BranchRel both asserted with Taken: absolute wins.
  - BranchRel/BranchAbs with Taken=0: PC+1, and the branch is not counted.
  - Start=1 in RUN aborts the run: next state ARM. This overrides Halt and branches. The PC reload happens in ARM.
- CycleCount increments by 1 on every RUN cycle, including the Halt cycle. It holds at 2^CNT_W-1.
- BranchCount increments by 1 on each RUN cycle where a taken branch or jump updates the PC (not on the Halt cycle). It holds at 2^CNT_W-1.
- DONE:
  - PC and counters hold.
  - Start=1 -> ARM.
- Halt, Branch*, Taken and Target are ignored outside RUN.

## Timing
- All outputs are registered. Running and Done are decoded from the state register; no combinational input-to-output paths.
- PC update latency is 1: decodes and Target sampled at edge N determine ProgCounter after edge N.
- Start handshake:
  - Start high at edge N -> ARM after N.
  - Start low at edge M -> RUN after M, with ProgCounter=START_ADDR during the first RUN cycle.
- Halt sampled in RUN at edge N -> Done=1 and Running=0 after N. ProgCounter still shows the halt instruction address.
- Reset asserted mid-run clears everything asynchronously, without waiting for a clock edge. Deassertion resumes in IDLE at the next edge.

## Test plan
- Reset/idle:
  - Stimulus: assert Reset mid-RUN with PC=37.
  - Required: ProgCounter=0, Done=0, Running=0, counts=0 before the next edge; then IDLE holds with Start=0.
- Sequential fetch and halt:
  - Stimulus: Start pulse of 2 cycles, then 5 RUN cycles with no decodes, then Halt.
  - Required: PC sequence 0,1,2,3,4,5; Done=1 with PC=5; CycleCount=6; BranchCount=0.
- Relative branch:
  - Stimulus: at PC=402, BranchRel=1, Taken=1, Target=-402 (10'h26E).
  - Required: next PC=0, BranchCount=1.
  - Stimulus: same decode with Taken=0.
  - Required: next PC=403, BranchCount unchanged.
- Absolute and priority:
  - Stimulus: at PC=10, BranchAbs=1, BranchRel=1, Taken=1, Target=700.
  - Required: next PC=700.
  - Stimulus: at PC=20, Halt=1 with BranchAbs&Taken.
  - Required: PC stays 20, DONE.
- Wrap-around:
  - Stimulus: PC=1023 with no decode.
  - Required: next PC=0.
  - Stimulus: PC=1000, BranchRel, Taken, Target=100.
  - Required: next PC=76.
- Restart/abort and saturation:
  - Stimulus: Start during RUN at PC=50.
  - Required: ARM, PC=0, counts cleared, resumes from 0 after Start drops.
  - Stimulus: with CNT_W=4, run for 20 cycles.
  - Required: CycleCount holds at 15.
